mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels, range 1..8.
REQ-002 Parameter DATA_W, default 32: data word width in bits.
REQ-003 Parameter DEPTH, default 256: backing RAM words, power of two, at least 4.
REQ-004 Parameter LATENCY, default 1: extra wait cycles per access, range 0..15.
REQ-005 Port clk  input  1: single clock, rising edge.
REQ-006 Port rst  input  1: reset, asynchronous, active-high.
REQ-007 Port ch_cs  input  NUM_CH: per-channel access request.
REQ-008 Port ch_we  input  NUM_CH: per-channel write enable; 0 selects a read.
REQ-009 Port ch_addr  input  NUM_CH*32: per-channel byte address, packed with channel 0 in the LSBs.
REQ-010 Port ch_din  input  NUM_CH*DATA_W: per-channel write data, packed.
REQ-011 Port ch_dout  output  NUM_CH*DATA_W: per-channel read data, registered, packed.
REQ-012 Port ch_stall  output  NUM_CH: per-channel stall back to the requester.

Function
REQ-013 Word index SHALL be addr[2 +: log2(DEPTH)]; upper address bits and bits [1:0] SHALL be ignored, so out-of-range addresses wrap.
REQ-014 ch_stall[i] SHALL equal ch_cs[i] AND NOT done[i], combinationally, where done[i] is high only in the DONE cycle of a channel-i access.
REQ-015 The requester SHALL hold cs, we, addr and din stable while its stall is high; the block SHALL sample them only at grant.
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 In IDLE with any cs high: grant one channel, latch its request, then go to BUSY if LATENCY>0, else go to DONE.
REQ-018 BUSY SHALL count exactly LATENCY cycles, then go to DONE.
REQ-019 In DONE: commit the write, or drive the read word onto that channel's ch_dout; then return to IDLE.
REQ-020 Access timing: cs presented in IDLE at cycle 0 -> stall high in cycles 0..LATENCY, stall low in cycle LATENCY+1.
REQ-021 Minimum spacing between back-to-back grants SHALL be LATENCY+2 cycles.
REQ-022 Arbitration SHALL be round-robin: search starts at the channel after the last one granted.
REQ-023 ch_dout of non-granted channels SHALL hold its previous value.
REQ-024 If cs of the granted channel drops before DONE:
  - a write SHALL still commit;
  - a read SHALL complete without updating ch_dout;
  - the FSM SHALL still pass through DONE.
REQ-025 Simultaneous requests from all channels SHALL be served in rotation, with no channel starved for more than NUM_CH grants.
REQ-026 A read in the cycle after a DONE write to the same word SHALL return the new data.

Reset
REQ-027 While rst is high:
  - FSM = IDLE;
  - round-robin pointer = NUM_CH-1, so channel 0 wins first;
  - every ch_dout = 0;
  - ch_stall = ch_cs.
REQ-028 rst mid-access SHALL abort the access: a pending write is not committed and no ch_dout update occurs.
REQ-029 RAM contents SHALL NOT be reset.

Configuration
REQ-030 Macro MEM_ARBITER_STATS_EN defined:
  - adds input stat_ch (3 bits), output stat_grants (32 bits) and output stat_waits (32 bits);
  - stat_grants is the grant count for channel stat_ch;
  - stat_waits is the count of cycles that channel had stall high;
  - both are wrapping 32-bit counters, cleared by rst;
  - stat_ch >= NUM_CH reads 0.
REQ-031 Macro undefined: these ports and counters SHALL be absent, and core behaviour SHALL be identical.

Structure
REQ-032 Package mem_arbiter_pkg SHALL hold:
  - the FSM state enum (IDLE, BUSY, DONE);
  - the latency counter width constant (4);
  - the stats port width constants.
REQ-033 Sub-module rr_arbiter (NUM_CH requests in, one-hot grant plus index out, pointer updated on an accept strobe) SHALL hold the round-robin logic.
REQ-034 The RAM SHALL be an inferred single-port DEPTH x DATA_W array inside mem_arbiter.

Verification (NUM_CH=2, DEPTH=256, LATENCY=2)
REQ-035 ch0 writes 0xDEADBEEF to 0x40, then reads 0x40 -> each access has stall high 3 cycles, low in cycle 3; ch_dout[0] = 0xDEADBEEF.
REQ-036 ch0 and ch1 both read from cycle 0 after reset -> ch0 completes at cycle 3, ch1 completes at cycle 7; ch1 stall high cycles 0..6.
REQ-037 Write 0x12345678 to 0x404, read 0x004 -> returns 0x12345678 (wrap).
REQ-038 ch1 write 0xA5A5A5A5 to 0x10, cs dropped at cycle 1 -> write committed; ch0 read of 0x10 returns 0xA5A5A5A5.
REQ-039 rst pulsed at cycle 1 of a ch0 write to 0x20 holding 0 -> FSM IDLE; a subsequent read of 0x20 returns 0; ch_dout cleared.
REQ-040 With MEM_ARBITER_STATS_EN, the REQ-036 sequence -> stat_grants = 1 for each channel; stat_waits = 3 (ch0) and 7 (ch1).

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and widths for the memory arbiter.
package mem_arbiter_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the BUSY wait counter (LATENCY up to 15)
    localparam int CNT_W = 4;

    // Statistics port widths
    localparam int STAT_CH_W = 3;
    localparam int STAT_W    = 32;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: round-robin grant among NUM_CH requests. The search begins one
// past the last accepted channel; the pointer moves only on an accept strobe.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic [IDX_W-1:0] ptr;

    // Pick the first requester found when rotating from ptr+1
    always_comb begin
        int         c;
        logic       found;
        logic [IDX_W-1:0] c_idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        c_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            c_idx = IDX_W'(c);
            if (!found && req[c_idx]) begin
                found   = 1'b1;
                gnt_idx = c_idx;
            end
        end
        if (found) gnt[gnt_idx] = 1'b1;
    end

    // Remember the accepted winner; reset value makes channel 0 win first
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= IDX_W'(NUM_CH - 1);
        else if (accept && |gnt)
            ptr <= gnt_idx;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_CH requesters share one single-port RAM through a
// round-robin arbiter and an IDLE/BUSY/DONE access sequencer.
// Build macro MEM_ARBITER_STATS_EN adds per-channel grant and wait counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_cs,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*32-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    output logic [NUM_CH*DATA_W-1:0] ch_dout,
    output logic [NUM_CH-1:0]        ch_stall
`ifdef MEM_ARBITER_STATS_EN
    ,
    input  logic [STAT_CH_W-1:0]     stat_ch,
    output logic [STAT_W-1:0]        stat_grants,
    output logic [STAT_W-1:0]        stat_waits
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    sel;
    logic                lat_we;
    logic [AW-1:0]       lat_addr;
    logic [DATA_W-1:0]   lat_din;
    logic [NUM_CH-1:0]   gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                accept;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_we;
    logic [AW-1:0]       rd_addr;
    logic                load_rd;
    logic [NUM_CH-1:0]   done;
    logic [AW-1:0]       addr_w [NUM_CH];
    logic [DATA_W-1:0]   din_w  [NUM_CH];
    logic [DATA_W-1:0]   dout_r [NUM_CH];
    logic [DATA_W-1:0]   mem    [DEPTH];
    logic                unused_addr_bits;

    // Unpack per-channel buses; only the word-index bits of an address matter
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign addr_w[g] = ch_addr[g*32 + 2 +: AW];
        assign din_w[g]  = ch_din[g*DATA_W +: DATA_W];
        assign ch_dout[g*DATA_W +: DATA_W] = dout_r[g];
    end
    assign unused_addr_bits = ^ch_addr;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (ch_cs),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept   = (state == IDLE) && |gnt;
    assign cur_idx  = (state == IDLE) ? gnt_idx : sel;
    assign cur_we   = (state == IDLE) ? ch_we[gnt_idx] : lat_we;
    assign rd_addr  = (state == IDLE) ? addr_w[gnt_idx] : lat_addr;
    assign ch_stall = ch_cs & ~done;

    // Next state, DONE strobe and read-load decision
    always_comb begin
        state_n = state;
        done    = '0;
        load_rd = 1'b0;
        unique case (state)
            IDLE:    if (accept) state_n = (LATENCY > 0) ? BUSY : DONE;
            BUSY:    if (cnt == LAST_CNT) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state == DONE) done[sel] = 1'b1;
        // A read whose requester has walked away completes without touching ch_dout
        load_rd = (state != DONE) && (state_n == DONE) && !cur_we && ch_cs[cur_idx];
    end

    // State register, granted channel and BUSY wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            lat_we <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                sel    <= gnt_idx;
                lat_we <= ch_we[gnt_idx];
                cnt    <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Request payload captured at grant and held through BUSY/DONE
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr <= addr_w[gnt_idx];
            lat_din  <= din_w[gnt_idx];
        end
    end

    // Write commits at the end of DONE; a reset before then leaves state IDLE
    always_ff @(posedge clk) begin
        if (state == DONE && lat_we)
            mem[lat_addr] <= lat_din;
    end

    // Read data lands on entry to DONE so it is valid while stall is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) dout_r[i] <= '0;
        end else if (load_rd) begin
            dout_r[cur_idx] <= mem[rd_addr];
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [STAT_W-1:0] grants [NUM_CH];
    logic [STAT_W-1:0] waits  [NUM_CH];

    // Wrapping per-channel counts of grants and stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                grants[i] <= '0;
                waits[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && gnt[i]) grants[i] <= grants[i] + STAT_W'(1);
                if (ch_stall[i])      waits[i]  <= waits[i] + STAT_W'(1);
            end
        end
    end

    // Counter readout for the selected channel; absent channels read zero
    always_comb begin
        stat_grants = '0;
        stat_waits  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(stat_ch) == i) begin
                stat_grants = grants[i];
                stat_waits  = waits[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed timing scenarios plus randomized two-channel
// traffic, checked by a read-data scoreboard and a per-cycle ch_dout model.
module tb_mem_arbiter;

    localparam int NUM_CH    = 2;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 256;
    localparam int LATENCY   = 2;
    localparam int MAX_STALL = NUM_CH * (LATENCY + 2) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_cs = '0;
    logic [1:0]  ch_we = '0;
    logic [63:0] ch_addr = '0;
    logic [63:0] ch_din = '0;
    logic [63:0] ch_dout;
    logic [1:0]  ch_stall;
`ifdef MEM_ARBITER_STATS_EN
    logic [2:0]  stat_ch = '0;
    logic [31:0] stat_grants;
    logic [31:0] stat_waits;
`endif

    mem_arbiter #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_cs    (ch_cs),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_din   (ch_din),
        .ch_dout  (ch_dout),
        .ch_stall (ch_stall)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_ch     (stat_ch),
        .stat_grants (stat_grants),
        .stat_waits  (stat_waits)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_dout [NUM_CH];
    int          n0, n1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // One requester transaction, started just after a rising edge.
    // drop_at >= 0 lowers cs after that many cycles and lets the access drain.
    task automatic access(input int ch, input bit we, input logic [31:0] addr,
                          input logic [31:0] din, input int drop_at, output int stall_n);
        int w;
        w = word_of(addr);
        ch_we[ch] = we;
        ch_addr[ch*32 +: 32] = addr;
        ch_din[ch*32 +: 32] = din;
        if (we) begin
            model_mem[w] = din;
            known[w] = 1'b1;
        end else if (drop_at < 0) begin
            if (ch == 0) exp_q0.push_back(model_mem[w]);
            else         exp_q1.push_back(model_mem[w]);
        end
        ch_cs[ch] = 1'b1;
        stall_n = 0;
        if (drop_at >= 0) begin
            repeat (drop_at) @(posedge clk);
            #1 ch_cs[ch] = 1'b0;
            repeat (LATENCY + 3) @(posedge clk);
            #1;
            stall_n = -1;
        end else begin
            @(negedge clk);
            while (ch_stall[ch] && stall_n < 60) begin
                stall_n++;
                @(negedge clk);
            end
            if (ch_stall[ch]) begin
                checks++;
                errors++;
                $display("FAIL timeout ch%0d: stall still high after %0d cycles", ch, stall_n);
            end
            @(posedge clk);
            #1 ch_cs[ch] = 1'b0;
        end
    endtask

    task automatic rand_chan(input int ch);
        int          n, w, k;
        logic [31:0] hi, a;
        logic [7:0]  wb;
        bit          we;
        for (int t = 0; t < 40; t++) begin
            w  = ch * 128 + int'($urandom_range(0, 7));
            wb = 8'(w);
            hi = $urandom;
            a  = {hi[21:0], wb, hi[31:30]};
            we = !known[w] || ($urandom_range(0, 1) == 1);
            access(ch, we, a, $urandom, -1, n);
            check($sformatf("stall_bound_ch%0d", ch), 64'(n <= MAX_STALL), 64'd1);
            k = int'($urandom_range(0, 2));
            if (k > 0) begin
                repeat (k) @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: pops expected read data on each read completion and checks
    // that every channel's ch_dout holds its modelled value each cycle.
    initial begin
        for (int i = 0; i < NUM_CH; i++) exp_dout[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NUM_CH; i++) exp_dout[i] = '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_cs[i] && !ch_stall[i] && !ch_we[i]) begin
                        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_read_ch%0d: got completion expected none", i);
                        end else begin
                            exp_dout[i] = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        end
                    end
                    check($sformatf("dout_ch%0d", i), 64'(ch_dout[i*32 +: 32]), 64'(exp_dout[i]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            known[i] = 1'b0;
        end

        // Reset state: stall follows cs, read data cleared
        ch_cs = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(ch_stall), 64'(2'b11));
        check("rst_dout", ch_dout, 64'd0);
        ch_cs = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;

        // Seed two words, then reset again: RAM contents survive reset
        access(0, 1'b1, 32'h100, 32'hC0C0_0001, -1, n0);
        access(1, 1'b1, 32'h104, 32'hC1C1_0002, -1, n1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst2_stall", 64'(ch_stall), 64'(2'b00));
        @(posedge clk);
        #1 rst = 1'b0;

        // Both channels read from cycle 0 after reset: ch0 first, ch1 waits 7
        fork
            access(0, 1'b0, 32'h100, 32'h0, -1, n0);
            access(1, 1'b0, 32'h104, 32'h0, -1, n1);
        join
        check("both_ch0_stall", 64'(n0), 64'd3);
        check("both_ch1_stall", 64'(n1), 64'd7);
        check("both_ch1_data", 64'(ch_dout[63:32]), 64'hC1C1_0002);
`ifdef MEM_ARBITER_STATS_EN
        stat_ch = 3'd0;
        #1;
        check("stat_grants_ch0", 64'(stat_grants), 64'd1);
        check("stat_waits_ch0", 64'(stat_waits), 64'd3);
        stat_ch = 3'd1;
        #1;
        check("stat_grants_ch1", 64'(stat_grants), 64'd1);
        check("stat_waits_ch1", 64'(stat_waits), 64'd7);
        stat_ch = 3'd5;
        #1;
        check("stat_out_of_range", 64'({stat_grants, stat_waits}), 64'd0);
`endif

        // Write then immediate read of the same word
        access(0, 1'b1, 32'h40, 32'hDEAD_BEEF, -1, n0);
        check("wr_stall", 64'(n0), 64'd3);
        access(0, 1'b0, 32'h40, 32'h0, -1, n0);
        check("rd_stall", 64'(n0), 64'd3);
        check("rd_data", 64'(ch_dout[31:0]), 64'hDEAD_BEEF);

        // Address wrap
        access(0, 1'b1, 32'h404, 32'h1234_5678, -1, n0);
        access(0, 1'b0, 32'h004, 32'h0, -1, n0);
        check("wrap_data", 64'(ch_dout[31:0]), 64'h1234_5678);

        // Write with cs dropped still commits
        access(1, 1'b1, 32'h10, 32'hA5A5_A5A5, 1, n1);
        access(0, 1'b0, 32'h10, 32'h0, -1, n0);
        check("drop_wr_data", 64'(ch_dout[31:0]), 64'hA5A5_A5A5);

        // Read with cs dropped leaves ch_dout untouched
        access(1, 1'b0, 32'h40, 32'h0, 1, n1);
        check("drop_rd_hold", 64'(ch_dout[63:32]), 64'hC1C1_0002);

        // Reset mid-write aborts it and clears read data
        access(0, 1'b1, 32'h20, 32'h0, -1, n0);
        ch_we[0] = 1'b1;
        ch_addr[31:0] = 32'h20;
        ch_din[31:0] = 32'hFFFF_0000;
        ch_cs[0] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        ch_cs[0] = 1'b0;
        @(negedge clk);
        check("abort_dout", ch_dout, 64'd0);
        check("abort_stall", 64'(ch_stall), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        access(0, 1'b0, 32'h20, 32'h0, -1, n0);
        check("abort_rd_stall", 64'(n0), 64'd3);
        check("abort_rd_data", 64'(ch_dout[31:0]), 64'd0);

        // Randomized concurrent traffic on disjoint word ranges
        fork
            rand_chan(0);
            rand_chan(1);
        join
        repeat (3) @(posedge clk);
        check("queue_drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
